// File: rtl/neureka_package.sv
// Shared constants and the FSM state type for the NEureka bit-serial column.
package neureka_package;

  localparam int unsigned NEUREKA_COLUMN_SIZE = 9;
  localparam int unsigned NEUREKA_QA_IN       = 8;
  localparam int unsigned NEUREKA_QW_MAX      = 8;

  // IDLE means the plane counter is zero; ACCUM means a result is in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } column_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/neureka_bitserial_column_if.sv
// Activation, weight-plane and result streams of the bit-serial column.
interface neureka_bitserial_column_if #(
  parameter int unsigned COLUMN_SIZE = neureka_package::NEUREKA_COLUMN_SIZE,
  parameter int unsigned QA_IN       = neureka_package::NEUREKA_QA_IN,
  parameter int unsigned QW_MAX      = neureka_package::NEUREKA_QW_MAX
);
  localparam int unsigned OUT_W = QA_IN + $clog2(COLUMN_SIZE) + QW_MAX + 1;

  logic [COLUMN_SIZE*QA_IN-1:0] act_data_i;
  logic                         act_valid_i;
  logic                         act_ready_o;
  logic [COLUMN_SIZE-1:0]       wgt_data_i;
  logic                         wgt_valid_i;
  logic                         wgt_ready_o;
  logic [OUT_W-1:0]             res_data_o;
  logic                         res_valid_o;
  logic                         res_ready_i;

  modport master (
    output act_data_i, act_valid_i, wgt_data_i, wgt_valid_i, res_ready_i,
    input  act_ready_o, wgt_ready_o, res_data_o, res_valid_o
  );

  modport slave (
    input  act_data_i, act_valid_i, wgt_data_i, wgt_valid_i, res_ready_i,
    output act_ready_o, wgt_ready_o, res_data_o, res_valid_o
  );

endinterface

// File: rtl/neureka_column_adder_tree.sv
// Masked lane sum: adds every activation whose weight bit (or offset) and lane enable are set.
module neureka_column_adder_tree
  import neureka_package::*;
#(
  parameter int unsigned COLUMN_SIZE = NEUREKA_COLUMN_SIZE,
  parameter int unsigned QA_IN       = NEUREKA_QA_IN
) (
  input  logic [COLUMN_SIZE*QA_IN-1:0]             act_i,
  input  logic [COLUMN_SIZE-1:0]                   wgt_i,
  input  logic                                     offset_i,
  input  logic [COLUMN_SIZE-1:0]                   mask_i,
  output logic [QA_IN+$clog2(COLUMN_SIZE)-1:0]     sum_o
);
  localparam int unsigned SUM_W = QA_IN + $clog2(COLUMN_SIZE);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < COLUMN_SIZE; i++) begin
      if (mask_i[i] & (wgt_i[i] | offset_i)) begin
        sum_o = sum_o + SUM_W'(act_i[i*QA_IN +: QA_IN]);
      end
    end
  end

endmodule

// File: rtl/neureka_bitserial_column.sv
// Bit-serial weight x activation column: one weight bit-plane per beat, shifted
// accumulation into a signed result with optional pipe register before the accumulator.
module neureka_bitserial_column
  import neureka_package::*;
#(
  parameter int unsigned COLUMN_SIZE = NEUREKA_COLUMN_SIZE,
  parameter int unsigned QA_IN       = NEUREKA_QA_IN,
  parameter int unsigned QW_MAX      = NEUREKA_QW_MAX,
  parameter int unsigned PIPELINE    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic [$clog2(QW_MAX+1)-1:0]  wgt_bits_i,
  input  logic                         signed_w_i,
  input  logic                         weight_offset_i,
  input  logic [COLUMN_SIZE-1:0]       lane_mask_i,
  neureka_bitserial_column_if.slave    bus
);
  localparam int unsigned SUM_W = QA_IN + $clog2(COLUMN_SIZE);
  localparam int unsigned OUT_W = SUM_W + QW_MAX + 1;
  localparam int unsigned NBW   = $clog2(QW_MAX + 1);
  localparam int unsigned BW    = clog2_min1(QW_MAX);

  column_state_e    state_q, state_d;
  logic [BW-1:0]    b_q, b_d;
  logic [NBW-1:0]   n_q, n_d, n_in, cur_n;
  logic             signed_q, signed_d, cur_signed;
  logic             ready, accept;
  logic             beat_first, beat_last;
  logic [SUM_W-1:0] lane_sum;

  logic             stg_vld, stg_first, stg_last, stg_neg;
  logic [BW-1:0]    stg_shift;
  logic [SUM_W-1:0] stg_sum;

  logic [OUT_W-1:0] acc_q, acc_d, acc_next, term, base;
  logic [OUT_W-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;

  assign ready  = rst_ni & enable_i & ~clear_i & (~res_valid_q | bus.res_ready_i);
  assign accept = bus.act_valid_i & bus.wgt_valid_i & ready;

  neureka_column_adder_tree #(
    .COLUMN_SIZE (COLUMN_SIZE),
    .QA_IN       (QA_IN)
  ) u_adder_tree (
    .act_i    (bus.act_data_i),
    .wgt_i    (bus.wgt_data_i),
    .offset_i (weight_offset_i),
    .mask_i   (lane_mask_i),
    .sum_o    (lane_sum)
  );

  always_comb begin
    n_in = wgt_bits_i;
    if (wgt_bits_i == '0) begin
      n_in = NBW'(1);
    end else if (32'(wgt_bits_i) > QW_MAX) begin
      n_in = NBW'(QW_MAX);
    end
  end

  // Plane count and signedness follow the live inputs only on the first beat.
  assign beat_first = (state_q == IDLE);
  assign cur_n      = beat_first ? n_in : n_q;
  assign cur_signed = beat_first ? signed_w_i : signed_q;
  assign beat_last  = (NBW'(b_q) == cur_n - NBW'(1));

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    n_d      = n_q;
    signed_d = signed_q;
    if (clear_i) begin
      state_d = IDLE;
      b_d     = '0;
    end else if (accept) begin
      if (beat_first) begin
        n_d      = n_in;
        signed_d = signed_w_i;
      end
      if (beat_last) begin
        state_d = IDLE;
        b_d     = '0;
      end else begin
        state_d = ACCUM;
        b_d     = b_q + BW'(1);
      end
    end
  end

  if (PIPELINE != 0) begin : g_pipe
    logic             vld_q, vld_d, first_q, first_d, last_q, last_d, neg_q, neg_d;
    logic [BW-1:0]    shift_q, shift_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
      vld_d   = vld_q;
      first_d = first_q;
      last_d  = last_q;
      neg_d   = neg_q;
      shift_d = shift_q;
      sum_d   = sum_q;
      if (clear_i) begin
        vld_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        neg_d   = 1'b0;
        shift_d = '0;
        sum_d   = '0;
      end else if (ready) begin
        vld_d   = accept;
        first_d = beat_first;
        last_d  = beat_last;
        neg_d   = cur_signed & beat_last;
        shift_d = b_q;
        sum_d   = lane_sum;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q   <= 1'b0;
        first_q <= 1'b0;
        last_q  <= 1'b0;
        neg_q   <= 1'b0;
        shift_q <= '0;
        sum_q   <= '0;
      end else begin
        vld_q   <= vld_d;
        first_q <= first_d;
        last_q  <= last_d;
        neg_q   <= neg_d;
        shift_q <= shift_d;
        sum_q   <= sum_d;
      end
    end

    assign stg_vld   = vld_q;
    assign stg_first = first_q;
    assign stg_last  = last_q;
    assign stg_neg   = neg_q;
    assign stg_shift = shift_q;
    assign stg_sum   = sum_q;
  end else begin : g_nopipe
    assign stg_vld   = accept;
    assign stg_first = beat_first;
    assign stg_last  = beat_last;
    assign stg_neg   = cur_signed & beat_last;
    assign stg_shift = b_q;
    assign stg_sum   = lane_sum;
  end

  // The first plane overwrites, so no separate accumulator clear is needed between results.
  assign term     = OUT_W'(stg_sum) << stg_shift;
  assign base     = stg_first ? '0 : acc_q;
  assign acc_next = stg_neg ? (base - term) : (base + term);

  always_comb begin
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    if (clear_i) begin
      acc_d       = '0;
      res_data_d  = '0;
      res_valid_d = 1'b0;
    end else if (ready) begin
      if (stg_vld) begin
        acc_d = acc_next;
      end
      if (stg_vld & stg_last) begin
        res_data_d  = acc_next;
        res_valid_d = 1'b1;
      end else if (bus.res_ready_i) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      b_q         <= '0;
      n_q         <= NBW'(1);
      signed_q    <= 1'b0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      n_q         <= n_d;
      signed_q    <= signed_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.act_ready_o = ready;
  assign bus.wgt_ready_o = ready;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_valid_o = res_valid_q;

endmodule

// File: tb/tb_neureka_bitserial_column.sv
// Scoreboard bench for neureka_bitserial_column (COLUMN_SIZE=9, QA_IN=8, QW_MAX=8, PIPELINE=1).
module tb_neureka_bitserial_column;

  logic       clk = 1'b0;
  logic       rst_n, clear, enable, signed_w, offset;
  logic [3:0] wgt_bits;
  logic [8:0] lane_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  neureka_bitserial_column_if #(.COLUMN_SIZE(9), .QA_IN(8), .QW_MAX(8)) bus ();

  neureka_bitserial_column #(
    .COLUMN_SIZE (9),
    .QA_IN       (8),
    .QW_MAX      (8),
    .PIPELINE    (1)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .enable_i        (enable),
    .wgt_bits_i      (wgt_bits),
    .signed_w_i      (signed_w),
    .weight_offset_i (offset),
    .lane_mask_i     (lane_mask),
    .bus             (bus)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [71:0] rep(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic int model(input logic [71:0] act, input logic [7:0][8:0] pl, input int n,
                               input bit sgn, input logic [8:0] mask, input bit off);
    int acc = 0;
    for (int b = 0; b < n; b++) begin
      int s = 0;
      for (int i = 0; i < 9; i++)
        if (mask[i] && (pl[b][i] || off)) s += int'(act[i*8 +: 8]);
      if (sgn && b == n - 1) acc -= s << b;
      else                   acc += s << b;
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_q.size() == 0) check_eq("spurious_res", exp_q.size(), 1);
      else check_eq("result", int'($signed(bus.res_data_o)), exp_q.pop_front());
    end
  end

  task automatic send_beat(input logic [71:0] act, input logic [8:0] w);
    int k = 0;
    bus.act_data_i  = act;
    bus.wgt_data_i  = w;
    bus.act_valid_i = 1'b1;
    bus.wgt_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.act_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.act_ready_o) check_eq("beat_timeout", int'(bus.act_ready_o), 1);
    @(posedge clk);
    #1;
    bus.act_valid_i = 1'b0;
    bus.wgt_valid_i = 1'b0;
  endtask

  task automatic run_result(input logic [71:0] act, input logic [7:0][8:0] pl,
                            input logic [3:0] nb, input bit sgn);
    int n;
    n = (nb == 0) ? 1 : ((nb > 8) ? 8 : int'(nb));
    wgt_bits = nb;
    signed_w = sgn;
    exp_q.push_back(model(act, pl, n, sgn, lane_mask, offset));
    for (int b = 0; b < n; b++) send_beat(act, pl[b]);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][8:0] pl;
    logic [3:0]      nb;

    rst_n = 1'b0; clear = 1'b0; enable = 1'b1; signed_w = 1'b0; offset = 1'b0;
    wgt_bits = 4'd1; lane_mask = '1;
    bus.act_data_i = '0; bus.wgt_data_i = '0;
    bus.act_valid_i = 1'b0; bus.wgt_valid_i = 1'b0; bus.res_ready_i = 1'b1;

    #12;
    check_eq("rst_act_ready", int'(bus.act_ready_o), 0);
    check_eq("rst_wgt_ready", int'(bus.wgt_ready_o), 0);
    check_eq("rst_res_valid", int'(bus.res_valid_o), 0);
    check_eq("rst_res_data", int'(bus.res_data_o), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", int'(bus.act_ready_o), 1);

    // N=1, act=10, all weights 1 -> 90
    pl = '0; pl[0] = 9'h1FF;
    run_result(rep(8'd10), pl, 4'd1, 1'b0);
    wait_drain();

    // N=4 unsigned w=5, act=3 -> 135, valid exactly 2 cycles after last beat
    pl = '0; pl[0] = 9'h1FF; pl[2] = 9'h1FF;
    run_result(rep(8'd3), pl, 4'd4, 1'b0);
    check_eq("lat_not_1cyc", int'(bus.res_valid_o), 0);
    @(posedge clk); #1;
    check_eq("lat_2cyc", int'(bus.res_valid_o), 1);
    wait_drain();

    // N=4 signed w=-1, act=2 -> -18, then 8 lanes -> -16
    pl = '1;
    run_result(rep(8'd2), pl, 4'd4, 1'b1);
    wait_drain();
    lane_mask = 9'h0FF;
    run_result(rep(8'd2), pl, 4'd4, 1'b1);
    wait_drain();
    lane_mask = '1;

    // Backpressure: first result held, second waits, order preserved
    bus.res_ready_i = 1'b0;
    pl = '0; pl[0] = 9'h1FF;
    run_result(rep(8'd1), pl, 4'd1, 1'b0);
    run_result(rep(8'd2), pl, 4'd1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("bp_ready_low", int'(bus.act_ready_o), 0);
      check_eq("bp_hold_data", int'($signed(bus.res_data_o)), 9);
    end
    bus.res_ready_i = 1'b1;
    wait_drain();

    // Clear after 2 of 4 planes: no result, then N=1 -> 9
    wgt_bits = 4'd4; signed_w = 1'b0;
    send_beat(rep(8'd5), 9'h1FF);
    send_beat(rep(8'd5), 9'h1FF);
    clear = 1'b1;
    #1 check_eq("clear_ready_low", int'(bus.act_ready_o), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("clear_no_valid", int'(bus.res_valid_o), 0);
    check_eq("clear_data_zero", int'(bus.res_data_o), 0);
    run_result(rep(8'd1), pl, 4'd1, 1'b0);
    wait_drain();

    // N=8, act=255, weight offset forces all planes -> 585225
    offset = 1'b1;
    pl = '0;
    run_result(rep(8'd255), pl, 4'd8, 1'b0);
    wait_drain();
    offset = 1'b0;

    // Clamp: wgt_bits=0 -> 1 plane, wgt_bits=15 -> 8 planes
    pl = '1;
    run_result(rep(8'd1), pl, 4'd0, 1'b0);
    wait_drain();
    run_result(rep(8'd1), pl, 4'd15, 1'b0);
    wait_drain();

    // Mid-result wgt_bits change ignored; enable low freezes
    wgt_bits = 4'd2; signed_w = 1'b0;
    exp_q.push_back(model(rep(8'd1), pl, 2, 1'b0, lane_mask, 1'b0));
    send_beat(rep(8'd1), 9'h1FF);
    wgt_bits = 4'd1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("en_low_ready", int'(bus.act_ready_o), 0);
    check_eq("en_low_no_res", int'(bus.res_valid_o), 0);
    enable = 1'b1;
    send_beat(rep(8'd1), 9'h1FF);
    wait_drain();

    // Random lanes, planes, masks, sign and plane counts
    for (int r = 0; r < 8; r++) begin
      lane_mask = 9'($urandom());
      pl = 72'({$urandom(), $urandom(), $urandom()});
      nb = 4'($urandom_range(0, 15));
      run_result(72'({$urandom(), $urandom(), $urandom()}), pl, nb, 1'($urandom()));
    end
    wait_drain();
    lane_mask = '1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_no_valid", int'(bus.res_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neureka_bitserial_column.md
NEUREKA_BITSERIAL_COLUMN -- requirements
Module: neureka_bitserial_column

Interface
REQ-001 Parameter COLUMN_SIZE, default NEUREKA_COLUMN_SIZE (9), SHALL set the number of activation/weight lanes.
REQ-002 Parameter QA_IN, default NEUREKA_QA_IN (8), SHALL set the unsigned activation width.
REQ-003 Parameter QW_MAX, default NEUREKA_QW_MAX (8), SHALL set the maximum weight bit-planes per result.
REQ-004 Parameter PIPELINE, default 1, SHALL insert (1) or omit (0) a register between the lane sum and the accumulator.
REQ-005 Derived OUT_W = QA_IN + $clog2(COLUMN_SIZE) + QW_MAX + 1 SHALL be the signed result width.
REQ-006 The block SHALL have one clock; reset SHALL be asynchronous and active-low, with ports named clk_i and rst_ni.
REQ-007 clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-008 clear_i  in  1  synchronous clear; enable_i  in  1  local enable.
REQ-009 act_data_i  in  COLUMN_SIZE*QA_IN  activations; act_valid_i  in  1; act_ready_o  out  1.
REQ-010 wgt_data_i  in  COLUMN_SIZE  one weight bit-plane; wgt_valid_i  in  1; wgt_ready_o  out  1.
REQ-011 wgt_bits_i  in  $clog2(QW_MAX+1)  bit-planes per result; signed_w_i  in  1  MSB plane negative; weight_offset_i  in  1  force all weight bits to 1; lane_mask_i  in  COLUMN_SIZE  lane enables.
REQ-012 res_data_o  out  OUT_W  signed result; res_valid_o  out  1; res_ready_i  in  1.

Function
REQ-013 A beat SHALL be accepted when act_valid_i & wgt_valid_i & act_ready_o; act_ready_o and wgt_ready_o SHALL be identical.
REQ-014 Ready SHALL be enable_i & ~clear_i & (~res_valid_o | res_ready_i); all state (pipe, accumulator, counter) SHALL advance only under this condition.
REQ-015 Lane sum SHALL be sum over i of act[i] when lane_mask_i[i] & (wgt_data_i[i] | weight_offset_i), else 0, width QA_IN+$clog2(COLUMN_SIZE), no overflow.
REQ-016 FSM states IDLE (plane counter b=0) and ACCUM (b>0); IDLE->ACCUM on accepted beat when N>1; ACCUM->IDLE on accepted beat with b=N-1; otherwise hold.
REQ-017 N SHALL be latched from wgt_bits_i and signed_w_i on the first beat of each result; value 0 or >QW_MAX SHALL be treated as 1 and QW_MAX respectively; mid-result changes ignored.
REQ-018 Each plane SHALL add (lane sum << b) to the accumulator, except subtract when signed mode and b=N-1; first plane SHALL overwrite, not add.
REQ-019 On the final plane the full result SHALL load the output register and set res_valid_o; latency from final accepted beat to res_valid_o SHALL be 1 cycle (PIPELINE=0) or 2 cycles (PIPELINE=1).
REQ-020 res_data_o SHALL be stable while res_valid_o & ~res_ready_i; res_valid_o clears on handshake unless a new result loads the same cycle.
REQ-021 clear_i SHALL have priority: zero accumulator, counter, pipe register, res_valid_o and res_data_o next edge; state returns to IDLE.
REQ-022 enable_i low SHALL freeze all state and hold outputs.

Reset
REQ-023 On rst_ni low: state IDLE, b=0, accumulator, pipe, res_data_o = 0, res_valid_o = 0, act_ready_o/wgt_ready_o = 0 while in reset.
REQ-024 Reset deassertion mid-result SHALL leave no partial result visible.

Structure
REQ-025 NEUREKA_QW_MAX and the state enum type SHALL live in neureka_package; COLUMN_SIZE/QA_IN defaults reuse existing package constants.
REQ-026 The masked lane sum SHALL be a combinational sub-module neureka_column_adder_tree.

Verification (COLUMN_SIZE=9, QA_IN=8, QW_MAX=8)
REQ-027 N=1, all act=10, all w=1, mask all-ones -> one result 90.
REQ-028 N=4 unsigned, planes 1,0,1,0 (w=5), act=3 -> 135; PIPELINE=1 valid 2 cycles after 4th beat.
REQ-029 N=4 signed, planes all 1 (w=-1), act=2 -> -18; lane_mask=0x0FF -> -16.
REQ-030 res_ready_i low, two N=1 results -> first held stable, ready drops, second emitted only after first handshake, order preserved.
REQ-031 clear_i after 2 of 4 planes -> no result, res_valid_o=0; next N=1 act=1 w=1 -> 9.
REQ-032 N=8 unsigned, act=255, all planes 1, weight_offset_i=1 -> 585225, no overflow.
